// File: rtl/ex_muldiv.sv
// EX-stage RV32M unit: iterative shift-add multiply and restoring divide.
// Stalls the pipeline while busy and emits the result for one DONE cycle.
module ex_muldiv #(
    parameter int              OPW        = 8,
    parameter int              SELW       = 3,
    parameter logic [SELW-1:0] SEL_MULDIV = 3'b101
) (
    input  logic            dclk,
    input  logic            rst,
    input  logic [OPW-1:0]  aluop_i,
    input  logic [SELW-1:0] alusel_i,
    input  logic [31:0]     regdata1_i,
    input  logic [31:0]     regdata2_i,
    input  logic            wreg_i,
    input  logic [4:0]      waddr_i,
    output logic [31:0]     wdata_o,
    output logic            wreg_o,
    output logic [4:0]      waddr_o,
    output logic            stl_req_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  f3_q, f3_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        spec_q, spec_d;
    logic [31:0] spec_val_q, spec_val_d;
    logic        wreg_q, wreg_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_hold_q;
    logic [4:0]  waddr_hold_q;

    logic [2:0]  f3;
    logic        start;
    logic        sgn1, sgn2;
    logic [31:0] mag1, mag2;
    logic        div_zero, div_ovf;
    logic [31:0] spec_val;
    logic        unused_op;

    assign unused_op = ^aluop_i[OPW-1:3];
    assign f3        = aluop_i[2:0];
    assign start     = rst && (state_q == S_IDLE) && (alusel_i == SEL_MULDIV);
    assign stl_req_o = rst && (start || (state_q == S_CALC));

    // rs1 is signed for MUL/MULH/MULHSU/DIV/REM; rs2 for MUL/MULH/DIV/REM
    assign sgn1 = regdata1_i[31] && !(f3 == 3'b011 || f3 == 3'b101 || f3 == 3'b111);
    assign sgn2 = regdata2_i[31] && !(f3 == 3'b010 || f3 == 3'b011 ||
                                      f3 == 3'b101 || f3 == 3'b111);
    assign mag1 = sgn1 ? (32'd0 - regdata1_i) : regdata1_i;
    assign mag2 = sgn2 ? (32'd0 - regdata2_i) : regdata2_i;

    assign div_zero = f3[2] && (regdata2_i == 32'd0);
    assign div_ovf  = f3[2] && !f3[0] && (regdata1_i == 32'h8000_0000) &&
                      (regdata2_i == 32'hFFFF_FFFF);
    assign spec_val = div_zero ? (f3[1] ? regdata1_i : 32'hFFFF_FFFF)
                               : (f3[1] ? 32'd0 : 32'h8000_0000);

    logic [32:0] msum;
    logic [32:0] shl;
    logic [32:0] diff;

    assign msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
    assign shl  = {hi_q, lo_q[31]};
    assign diff = shl - {1'b0, b_q};

    logic [63:0] prod_s;
    logic [31:0] mul_res, quo, rem, res;

    assign prod_s  = (s1_q ^ s2_q) ? (64'd0 - {hi_q, lo_q}) : {hi_q, lo_q};
    assign mul_res = (f3_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
    assign quo     = (s1_q ^ s2_q) ? (32'd0 - lo_q) : lo_q;
    assign rem     = s1_q ? (32'd0 - hi_q) : hi_q;
    assign res     = spec_q ? spec_val_q :
                     f3_q[2] ? (f3_q[1] ? rem : quo) : mul_res;

    assign wdata_o = (state_q == S_DONE) ? res : wdata_hold_q;
    assign waddr_o = (state_q == S_DONE) ? waddr_q : waddr_hold_q;
    assign wreg_o  = (state_q == S_DONE) && wreg_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        b_d        = b_q;
        f3_d       = f3_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        wreg_d     = wreg_q;
        waddr_d    = waddr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    f3_d       = f3;
                    s1_d       = sgn1;
                    s2_d       = sgn2;
                    spec_d     = div_zero || div_ovf;
                    spec_val_d = spec_val;
                    wreg_d     = wreg_i;
                    waddr_d    = waddr_i;
                    cnt_d      = 6'd0;
                    hi_d       = 32'd0;
                    lo_d       = f3[2] ? mag1 : mag2;
                    b_d        = f3[2] ? mag2 : mag1;
                    state_d    = (div_zero || div_ovf) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (f3_q[2]) begin
                    hi_d = diff[32] ? shl[31:0] : diff[31:0];
                    lo_d = {lo_q[30:0], ~diff[32]};
                end else begin
                    hi_d = msum[32:1];
                    lo_d = {msum[0], lo_q[31:1]};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    cnt_d   = 6'd0;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge dclk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 6'd0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            b_q          <= 32'd0;
            f3_q         <= 3'd0;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            spec_q       <= 1'b0;
            spec_val_q   <= 32'd0;
            wreg_q       <= 1'b0;
            waddr_q      <= 5'd0;
            wdata_hold_q <= 32'd0;
            waddr_hold_q <= 5'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            b_q        <= b_d;
            f3_q       <= f3_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            wreg_q     <= wreg_d;
            waddr_q    <= waddr_d;
            if (state_q == S_DONE) begin
                wdata_hold_q <= res;
                waddr_hold_q <= waddr_q;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomised and directed checks of ex_muldiv against an arithmetic model.
// Covers latency, stall window, special cases, reset mid-op and holds.
module tb_ex_muldiv;

    localparam logic [2:0] SEL_M   = 3'b101;
    localparam logic [2:0] SEL_ADD = 3'b001;

    logic        dclk;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] regdata1_i;
    logic [31:0] regdata2_i;
    logic        wreg_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_o;
    logic        wreg_o;
    logic [4:0]  waddr_o;
    logic        stl_req_o;

    int n_chk;
    int n_fail;
    logic [31:0] last_res;
    logic [4:0]  last_wa;

    ex_muldiv dut (
        .dclk      (dclk),
        .rst       (rst),
        .aluop_i   (aluop_i),
        .alusel_i  (alusel_i),
        .regdata1_i(regdata1_i),
        .regdata2_i(regdata2_i),
        .wreg_i    (wreg_i),
        .waddr_i   (waddr_i),
        .wdata_o   (wdata_o),
        .wreg_o    (wreg_o),
        .waddr_o   (waddr_o),
        .stl_req_o (stl_req_o)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        model = 32'd0;
        case (f3)
            3'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; model = p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; model = p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; model = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; model = p[63:32]; end
            3'd4: model = (b == 0) ? 32'hFFFF_FFFF :
                          (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 :
                          32'(sa / sb);
            3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: model = (b == 0) ? a :
                          (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 :
                          32'(sa % sb);
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit special(input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] b);
        special = f3[2] && (b == 0 ||
                  (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wa, input logic we);
        logic [31:0] exp;
        int lat;
        exp = model(f3, a, b);
        lat = special(f3, a, b) ? 1 : 33;
        @(posedge dclk); #1;
        alusel_i   = SEL_M;
        aluop_i    = {5'b10110, f3};
        regdata1_i = a;
        regdata2_i = b;
        wreg_i     = we;
        waddr_i    = wa;
        #1;
        chk({tag, "_stl_start"}, 32'(stl_req_o), 32'd1);
        for (int k = 1; k <= lat; k++) begin
            @(posedge dclk); #1;
            if (k < lat) begin
                chk({tag, "_stl_busy"}, 32'(stl_req_o), 32'd1);
                chk({tag, "_wreg_busy"}, 32'(wreg_o), 32'd0);
            end else begin
                chk({tag, "_stl_done"}, 32'(stl_req_o), 32'd0);
                chk({tag, "_wreg"}, 32'(wreg_o), 32'(we));
                chk({tag, "_wdata"}, wdata_o, exp);
                chk({tag, "_waddr"}, 32'(waddr_o), 32'(wa));
            end
        end
        last_res = exp;
        last_wa  = wa;
    endtask

    task automatic bubble(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge dclk); #1;
            alusel_i = SEL_ADD;
            aluop_i  = 8'h00;
            #1;
            chk("bubble_stl", 32'(stl_req_o), 32'd0);
            chk("bubble_wreg", 32'(wreg_o), 32'd0);
            chk("hold_wdata", wdata_o, last_res);
            chk("hold_waddr", 32'(waddr_o), 32'(last_wa));
        end
    endtask

    task automatic reset_mid_div();
        @(posedge dclk); #1;
        alusel_i   = SEL_M;
        aluop_i    = 8'h04;
        regdata1_i = 32'h1234_5678;
        regdata2_i = 32'd3;
        wreg_i     = 1'b1;
        waddr_i    = 5'd9;
        #1;
        chk("rdiv_stl_start", 32'(stl_req_o), 32'd1);
        for (int k = 1; k <= 9; k++) begin
            @(posedge dclk); #1;
        end
        @(posedge dclk); #1;
        rst = 1'b0;
        #1;
        chk("rdiv_stl_in_rst", 32'(stl_req_o), 32'd0);
        @(posedge dclk); #1;
        chk("rdiv_wdata", wdata_o, 32'd0);
        chk("rdiv_wreg", 32'(wreg_o), 32'd0);
        chk("rdiv_waddr", 32'(waddr_o), 32'd0);
        chk("rdiv_stl", 32'(stl_req_o), 32'd0);
        rst      = 1'b1;
        alusel_i = SEL_ADD;
        #1;
        chk("rdiv_stl_after", 32'(stl_req_o), 32'd0);
        for (int k = 0; k < 40; k++) begin
            @(posedge dclk); #1;
            chk("rdiv_no_pulse", 32'(wreg_o), 32'd0);
        end
        last_res = 32'd0;
        last_wa  = 5'd0;
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        last_res   = 32'd0;
        last_wa    = 5'd0;
        rst        = 1'b0;
        alusel_i   = SEL_M;
        aluop_i    = 8'h00;
        regdata1_i = 32'd3;
        regdata2_i = 32'd4;
        wreg_i     = 1'b1;
        waddr_i    = 5'd1;
        repeat (3) @(posedge dclk);
        #1;
        chk("rst_stl", 32'(stl_req_o), 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_wreg", 32'(wreg_o), 32'd0);
        chk("rst_waddr", 32'(waddr_o), 32'd0);
        rst      = 1'b1;
        alusel_i = SEL_ADD;
        bubble(2);

        run_op("mul_7xm3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
        bubble(2);
        run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b1);
        run_op("mulh_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b1);
        run_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b1);
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, 1'b1);
        run_op("divu_m7_2", 3'd5, 32'hFFFF_FFF9, 32'd2, 5'd12, 1'b1);
        run_op("divu_by0", 3'd5, 32'd1234, 32'd0, 5'd13, 1'b1);
        run_op("remu_by0", 3'd7, 32'd1234, 32'd0, 5'd14, 1'b1);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b1);
        bubble(1);
        run_op("b2b_mul1", 3'd0, 32'd3, 32'd4, 5'd17, 1'b1);
        run_op("b2b_mul2", 3'd0, 32'd5, 32'd6, 5'd18, 1'b1);
        bubble(3);
        run_op("waddr0", 3'd0, 32'd9, 32'd9, 5'd0, 1'b1);
        run_op("wreg_off", 3'd5, 32'd100, 32'd7, 5'd19, 1'b0);
        bubble(1);
        reset_mid_div();
        bubble(1);

        for (int i = 0; i < 16; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            run_op("rand", f3, a, b, 5'($urandom), 1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 1) == 1) bubble(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
